// File: rtl/sw_chain_pkg.sv
// sw_chain_pkg: shared constants, types and sizing helper for the switch-chain evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sw_chain_pkg;

  // Side switches feeding every stage after the first (B, C, D).
  localparam int SIDE_INPUTS = 3;

  // Truth-table width of one four-input stage.
  localparam int LUT_W = 16;

  // Width of the saturating change counter.
  localparam int CHG_CNT_W = 8;

  typedef logic [CHG_CNT_W-1:0] chg_cnt_t;

  // Switch count for a chain: four inputs on stage 0, three new ones per later stage.
  function automatic int nsw(input int num_stages);
    return SIDE_INPUTS * num_stages + 1;
  endfunction

endpackage

// File: rtl/sw_chain_eval_if.sv
// sw_chain_eval_if: raw switches in, LED word plus change strobe/count out.
// Latency: n/a (wiring only).
// Backpressure: none; the evaluator free-runs on every cycle.
interface sw_chain_eval_if import sw_chain_pkg::*; #(
  parameter int NUM_STAGES = 2
);

  localparam int NSW = nsw(NUM_STAGES);

  logic [NSW-1:0]        sw;
  logic [NUM_STAGES-1:0] led;
  logic                  change;
  chg_cnt_t              change_count;

  // The evaluator consumes switches and drives the LED side.
  modport master (input sw, output led, change, change_count);

  // Board side: drives switches, observes LEDs.
  modport slave (output sw, input led, change, change_count);

endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: accepts a new level on one synchronised switch after it holds for DEBOUNCE_CYCLES.
// Latency: DEBOUNCE_CYCLES cycles from the first differing synced sample to dout.
// Backpressure: none; a bounce back to the stable level before acceptance just restarts the count.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive mismatch cycles; take the new level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sw_chain_eval.sv
// sw_chain_eval: sync (+ optional debounce, macro SW_CHAIN_DEBOUNCE_EN) switches, evaluate chained LUT stages to LEDs.
// Latency: led[k] moves 3+k cycles after a switch change, plus DEBOUNCE_CYCLES when the debouncer is built in.
// Backpressure: none; one switch snapshot per cycle, never stalls.
module sw_chain_eval import sw_chain_pkg::*; #(
  parameter int                          NUM_STAGES      = 2,
  parameter logic [NUM_STAGES*LUT_W-1:0] STAGE_LUT       = {16'hFFFE, 16'h8000},
  parameter int                          DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  sw_chain_eval_if.master bus
);

  localparam int NSW      = nsw(NUM_STAGES);
  localparam int STAGE_IN = SIDE_INPUTS + 1;

  if (NUM_STAGES < 1 || DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("sw_chain_eval: NUM_STAGES and DEBOUNCE_CYCLES must both be at least 1");
  end

  logic [NSW-1:0]        sync_q1;
  logic [NSW-1:0]        sync_q2;
  logic [NSW-1:0]        deb;
  logic [NUM_STAGES-1:0] y;
  logic [NUM_STAGES-1:0] y_next;
  logic                  led_diff;
  logic                  change_q;
  chg_cnt_t              count_q;

  // Two-flop synchroniser on every raw switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.sw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SW_CHAIN_DEBOUNCE_EN
  for (genvar i = 0; i < NSW; i++) begin : g_deb
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sync_q2[i]),
      .dout (deb[i])
    );
  end
`else
  // Without the debouncer the chain sees the synchroniser output directly.
  assign deb = sync_q2;
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [LUT_W-1:0]    lut;
    logic [STAGE_IN-1:0] idx;

    assign lut = STAGE_LUT[LUT_W*k +: LUT_W];

    if (k == 0) begin : g_head
      // Stage 0 takes A..D straight from the snapshot: {D,C,B,A} = sw[3:0].
      assign idx = deb[STAGE_IN-1:0];
    end else begin : g_tail
      // dly holds k snapshots of this stage's side switches, newest in the low bits.
      logic [SIDE_INPUTS*k-1:0]     dly;
      logic [SIDE_INPUTS*(k+1)-1:0] taps;

      assign taps = {dly, deb[SIDE_INPUTS*k+1 +: SIDE_INPUTS]};

      // Age the side switches k cycles so they meet Y of stage k-1 from the same snapshot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly <= '0;
        end else begin
          dly <= taps[SIDE_INPUTS*k-1:0];
        end
      end

      assign idx = {dly[SIDE_INPUTS*k-1 -: SIDE_INPUTS], y[k-1]};
    end

    assign y_next[k] = lut[idx];
  end

  assign led_diff = (y_next != y);

  // Register the stage outputs together with the change strobe and its saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= '0;
      change_q <= 1'b0;
      count_q  <= '0;
    end else begin
      y        <= y_next;
      change_q <= led_diff;
      if (led_diff && (count_q != '1)) begin
        count_q <= count_q + chg_cnt_t'(1);
      end
    end
  end

  assign bus.led          = y;
  assign bus.change       = change_q;
  assign bus.change_count = count_q;

endmodule

// File: tb/tb_sw_chain_eval.sv
// tb_sw_chain_eval: table vectors, corner sequences and random stimulus against a behavioural model.
// Latency: expectations follow the sync / debounce / per-stage alignment timing of the chain.
// Backpressure: n/a.
module tb_sw_chain_eval;
  import sw_chain_pkg::*;

  localparam int D = 4;
`ifdef SW_CHAIN_DEBOUNCE_EN
  localparam int DLAT = D;
  localparam int GLITCH_EXP = 0;
`else
  localparam int DLAT = 0;
  localparam int GLITCH_EXP = 20;
`endif
  localparam int LAT0 = 3 + DLAT;
  localparam logic [31:0] LUT2 = {16'hFFFE, 16'h8000};
  localparam logic [47:0] LUT3 = {16'h8000, 16'h8000, 16'h8000};
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;

  always #5 clk = ~clk;

  sw_chain_eval_if #(.NUM_STAGES(2)) bus2 ();
  sw_chain_eval_if #(.NUM_STAGES(3)) bus3 ();

  sw_chain_eval #(.NUM_STAGES(2), .STAGE_LUT(LUT2), .DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  sw_chain_eval #(.NUM_STAGES(3), .STAGE_LUT(LUT3), .DEBOUNCE_CYCLES(D)) dut3 (
    .clk  (clk),
    .rst_n(rst3_n),
    .bus  (bus3)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state, indexed by clock edge since reset release.
  logic [6:0] raw_h [MAXE];
  logic [6:0] syn_h [MAXE];
  logic [6:0] deb_h [MAXE];
  int         e;
  logic [1:0] led_m;
  logic       chg_m;
  int         cnt_m;

  typedef struct packed {
    logic [6:0] sw;
    logic [1:0] led;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Default chain: stage 0 is AND of sw0..sw3, stage 1 is OR of stage 0 with sw4..sw6.
  function automatic logic [1:0] chain2(input logic [6:0] s);
    logic y0;
    y0 = &s[3:0];
    return {y0 | (|s[6:4]), y0};
  endfunction

  task automatic model_reset();
    e        = 0;
    raw_h[0] = '0;
    syn_h[0] = '0;
    deb_h[0] = '0;
    led_m    = '0;
    chg_m    = 1'b0;
    cnt_m    = 0;
  endtask

  task automatic model_step(input logic [6:0] v);
    logic [6:0] nd;
    logic [1:0] nl;
    e++;
    raw_h[e] = v;
    syn_h[e] = (e >= 2) ? raw_h[e-1] : 7'h0;
`ifdef SW_CHAIN_DEBOUNCE_EN
    // A switch flips when the last D synced samples all disagree with its held level.
    for (int b = 0; b < 7; b++) begin
      logic stable;
      bit   all_diff;
      stable   = deb_h[e-1][b];
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) begin
        logic [6:0] s;
        s = (e - j >= 0) ? syn_h[e-j] : 7'h0;
        if (s[b] == stable) all_diff = 1'b0;
      end
      nd[b] = all_diff ? ~stable : stable;
    end
`else
    nd = syn_h[e];
`endif
    deb_h[e] = nd;
    for (int k = 0; k < 2; k++) begin
      logic [6:0] snap;
      logic [1:0] c;
      snap  = (e - 1 - k >= 0) ? deb_h[e-1-k] : 7'h0;
      c     = chain2(snap);
      nl[k] = c[k];
    end
    chg_m = (nl != led_m);
    if (chg_m && cnt_m < 255) cnt_m++;
    led_m = nl;
  endtask

  task automatic step(input logic [6:0] v);
    bus2.sw = v;
    @(posedge clk);
    model_step(v);
    #1;
    check("model_led", bus2.led, led_m);
    check("model_change", bus2.change, chg_m);
    check("model_count", bus2.change_count, cnt_m);
  endtask

  task automatic do_reset(input logic [6:0] v);
    rst_n   = 1'b0;
    bus2.sw = v;
    #1;
    check("rst_led", bus2.led, 0);
    check("rst_change", bus2.change, 0);
    check("rst_count", bus2.change_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_vec(input string name, input logic [6:0] v, input logic [1:0] led_exp,
                         input logic [7:0] cnt_exp);
    logic [1:0] exp;
    do_reset(v);
    for (int cyc = 1; cyc <= LAT0 + 4; cyc++) begin
      step(v);
      exp[0] = led_exp[0] && (cyc >= LAT0);
      exp[1] = led_exp[1] && (cyc >= LAT0 + 1);
      check({name, "_led"}, bus2.led, exp);
    end
    check({name, "_count"}, bus2.change_count, cnt_exp);
  endtask

  initial begin
    logic [9:0] exp3;
    logic [6:0] v;
    int         hold;

    vecs[0] = '{sw: 7'h0F, led: 2'b11, cnt: 8'd2};
    vecs[1] = '{sw: 7'h10, led: 2'b10, cnt: 8'd1};
    vecs[2] = '{sw: 7'h07, led: 2'b00, cnt: 8'd0};
    vecs[3] = '{sw: 7'h20, led: 2'b10, cnt: 8'd1};
    vecs[4] = '{sw: 7'h7F, led: 2'b11, cnt: 8'd2};
    vecs[5] = '{sw: 7'h00, led: 2'b00, cnt: 8'd0};
    vecs[6] = '{sw: 7'h0E, led: 2'b00, cnt: 8'd0};
    vecs[7] = '{sw: 7'h41, led: 2'b10, cnt: 8'd1};

    rst_n   = 1'b1;
    rst3_n  = 1'b1;
    bus2.sw = '0;
    bus3.sw = '0;
    model_reset();
    #2;

    // Table: each vector from reset, with per-edge timing of every LED bit.
    for (int i = 0; i < 8; i++) begin
      run_vec("vec", vecs[i].sw, vecs[i].led, vecs[i].cnt);
    end

    // Glitch: sw0 toggles every 2 cycles for 20 cycles on top of sw1..sw3 high.
    do_reset(7'h0E);
    for (int i = 0; i < 8; i++) step(7'h0E);
    for (int t = 0; t < 10; t++) begin
      v = (t % 2 == 0) ? 7'h0F : 7'h0E;
      step(v);
      step(v);
    end
    for (int i = 0; i < 12; i++) step(7'h0E);
    check("glitch_count", bus2.change_count, GLITCH_EXP);

    // Reset in the middle of a debounce, then full latency again from release.
    run_vec("pre_mid", 7'h0F, 2'b11, 8'd2);
    for (int i = 0; i < 5; i++) step(7'h00);
    run_vec("post_mid", 7'h0F, 2'b11, 8'd2);

    // Saturation: 300 accepted transitions on sw4, then one more.
    do_reset(7'h00);
    for (int i = 0; i < 8; i++) step(7'h00);
    for (int i = 0; i < 300; i++) begin
      v = (i % 2 == 0) ? 7'h10 : 7'h00;
      for (int h = 0; h < DLAT + 4; h++) step(v);
    end
    check("sat_count", bus2.change_count, 255);
    for (int h = 0; h < DLAT + 6; h++) step(7'h10);
    check("sat_hold_count", bus2.change_count, 255);
    check("sat_hold_led", bus2.led, 2'b10);

    // Random switch patterns with random hold lengths.
    do_reset(7'($urandom));
    for (int s = 0; s < 80; s++) begin
      v    = 7'($urandom);
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) step(v);
    end

    // Three-stage AND chain with every switch high: LED bits rise one edge apart.
    rst3_n  = 1'b0;
    bus3.sw = 10'h3FF;
    #1;
    check("c3_rst_led", bus3.led, 0);
    @(negedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    for (int cyc = 1; cyc <= LAT0 + 5; cyc++) begin
      @(posedge clk);
      #1;
      exp3 = '0;
      for (int k = 0; k < 3; k++) if (cyc >= LAT0 + k) exp3[k] = 1'b1;
      check("c3_led", bus3.led, exp3);
    end
    check("c3_count", bus3.change_count, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sw_chain_eval.md
# sw_chain_eval

Parametrised, registered successor to the two-stage switch-to-LED logic chain. Evaluates a chain of NUM_STAGES four-input logic stages. Each stage's function is set by a 16-bit truth table, and each stage feeds the next. Switch inputs pass through a synchroniser and an optional debouncer; stage outputs are pipelined, aligned to one switch snapshot, and driven to LEDs, with a change strobe and a saturating change counter. It sits directly under the board top, between the raw switches and the LEDs.

## Interface
- NUM_STAGES, 2, number of chained stages (≥1); switch count NSW = 3*NUM_STAGES+1
- STAGE_LUT, {16'hFFFE,16'h8000}, NUM_STAGES×16 packed truth tables; bits [16k+15:16k] = stage k; default stage0 AND4, stage1 OR4
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a switch change is accepted (≥1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  NSW  raw asynchronous switches
- led  out  NUM_STAGES  registered stage outputs, led[k] = Y of stage k
- change  out  1  one-cycle pulse when any led bit changes
- change_count  out  8  saturating count of change pulses

## Operation
- Synchroniser: 2 flops per switch, reset 0.
- Debouncer, per switch: keeps a stable value and a counter. When the synced value equals the stable value, the counter clears. Otherwise the counter increments. On the DEBOUNCE_CYCLES-th consecutive mismatch cycle, the stable value takes the synced value and the counter clears. A bounce back to the stable value before acceptance clears the counter with no output change.
- Stage k function: Y = STAGE_LUT[16k + {D,C,B,A}].
  - Stage 0: A=sw0, B=sw1, C=sw2, D=sw3.
  - Stage k>0: A=Y of stage k-1 (registered), B=sw[3k+1], C=sw[3k+2], D=sw[3k+3].
- Alignment: stage k's side switches are delayed k cycles through a per-stage pipeline, so all led bits reflect the same debounced snapshot.
- change: registered with led; high in the cycle led first shows a value different from its previous value.
- change_count: increments on each change pulse and holds at 255.
- Reset (asserted at any time, including mid-debounce): clears synchronisers, stable values, counters, pipeline, led, change and change_count to 0. After release, state rebuilds with full latency.

## Timing
- Reset values: led=0, change=0, change_count=0.
- Switch toggled before clock edge 1, held stable:
  - synced value visible after edge 2
  - debounced value updates at edge 2+DEBOUNCE_CYCLES
  - led[k] updates at edge 3+DEBOUNCE_CYCLES+k
- Change pulses: a change visible in several stages produces one change pulse per cycle in which led differs, up to NUM_STAGES consecutive pulses.
- Throughput: one snapshot per cycle; no stalls.

## Configuration
- SW_CHAIN_DEBOUNCE_EN defined: debouncer instantiated as described.
- Undefined: the debounced value equals the synchroniser output, DEBOUNCE_CYCLES is ignored, and led[k] updates at edge 3+k.

## Structure
- Package sw_chain_pkg holds:
  - SIDE_INPUTS=3
  - LUT_W=16
  - function nsw(num_stages)
  - change counter width 8
- Sub-module sw_debounce: one switch; params DEBOUNCE_CYCLES; ports clk, rst_n, din (synced), dout. Counter width $clog2(DEBOUNCE_CYCLES+1). Instantiated NSW times in a generate loop.
- Stage evaluation and the alignment pipeline stay in sw_chain_eval.

## Test plan
- Reset, then sw=7'h0F held, defaults, DEBOUNCE_CYCLES=4, SW_CHAIN_DEBOUNCE_EN defined → led=2'b11 at edge 7 (led[0]) and edge 8 (led[1]). Two change pulses; change_count=2.
- sw0 toggles every 2 cycles for 20 cycles with DEBOUNCE_CYCLES=4 → no led change, change never asserts.
- sw=7'h10 (sw4 only) held → led=2'b10 at edge 8, led[0] stays 0, one pulse.
- Reset asserted mid-debounce (3 mismatch cycles into a 4-cycle debounce) → all outputs 0 immediately. After release, sw still set → led updates at the full latency from the release edge.
- 300 alternating accepted transitions on sw4 → change_count reaches 255 and holds.
- SW_CHAIN_DEBOUNCE_EN undefined, NUM_STAGES=3, STAGE_LUT all 16'h8000, sw=10'h3FF → led=3'b001, 3'b011, 3'b111 at edges 3, 4, 5.
